// File: rtl/program_counter_stack.sv
// SAP-1 program counter with a call/return stack and sticky overflow/underflow flag.
// pc/sp/flags update on the CLK edge; bus_out is combinational from pc and Ep; there is no backpressure, and one command executes per edge.
module program_counter_stack #(
  parameter int                ADDR_W      = 4,
  parameter int                STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR  = '0,
  localparam int               SP_W        = $clog2(STACK_DEPTH + 1)
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              Cp,
  input  logic              Ej,
  input  logic              Ecall,
  input  logic              Eret,
  input  logic              Ep,
  input  logic [ADDR_W-1:0] Addr,
  output logic [ADDR_W-1:0] bus_out,
  output logic [ADDR_W-1:0] pc,
  output logic [SP_W-1:0]   sp,
  output logic              stack_full,
  output logic              stack_empty,
  output logic              stack_err
);

  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [ADDR_W-1:0] stack [STACK_DEPTH];
  logic [ADDR_W-1:0] pc_inc;
  logic [IDX_W-1:0]  push_idx;
  logic [IDX_W-1:0]  pop_idx;

  assign pc_inc      = pc + ADDR_W'(1);
  assign stack_full  = (sp == SP_W'(STACK_DEPTH));
  assign stack_empty = (sp == '0);
  assign bus_out     = Ep ? pc : '0;

  // Indices are only used when the push/pop is legal, so truncation is safe.
  assign push_idx = IDX_W'(sp);
  assign pop_idx  = IDX_W'(sp - SP_W'(1));

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      pc        <= RESET_ADDR;
      sp        <= '0;
      stack_err <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) begin
        stack[i] <= '0;
      end
    end else if (Eret) begin
      if (stack_empty) begin
        stack_err <= 1'b1;
      end else begin
        pc <= stack[pop_idx];
        sp <= sp - SP_W'(1);
      end
    end else if (Ecall) begin
      if (stack_full) begin
        stack_err <= 1'b1;
      end else begin
        stack[push_idx] <= pc_inc;
        sp              <= sp + SP_W'(1);
        pc              <= Addr;
      end
    end else if (Ej) begin
      pc <= Addr;
    end else if (Cp) begin
      pc <= pc_inc;
    end
  end

endmodule

// File: tb/tb_program_counter_stack.sv
// Directed-vector bench for program_counter_stack (ADDR_W=4, STACK_DEPTH=4, RESET_ADDR=0).
module tb_program_counter_stack;

  logic       CLK = 1'b0;
  logic       CLR, Cp, Ej, Ecall, Eret, Ep;
  logic [3:0] Addr;
  logic [3:0] bus_out, pc;
  logic [2:0] sp;
  logic       stack_full, stack_empty, stack_err;

  int nvec = 0;
  int nbad = 0;

  program_counter_stack #(.ADDR_W(4), .STACK_DEPTH(4), .RESET_ADDR(4'd0)) dut (
    .CLK(CLK), .CLR(CLR), .Cp(Cp), .Ej(Ej), .Ecall(Ecall), .Eret(Eret), .Ep(Ep),
    .Addr(Addr), .bus_out(bus_out), .pc(pc), .sp(sp),
    .stack_full(stack_full), .stack_empty(stack_empty), .stack_err(stack_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       clr, cp, ej, ecall, eret, ep;
    logic [3:0] addr;
    logic [3:0] pc;
    logic [2:0] sp;
    logic       err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic clr, cp, ej, ecall, eret, ep,
                             input int addr, epc, esp, input logic err);
    vec_t r;
    r.clr = clr; r.cp = cp; r.ej = ej; r.ecall = ecall; r.eret = eret; r.ep = ep;
    r.addr = 4'(addr); r.pc = 4'(epc); r.sp = 3'(esp); r.err = err;
    return r;
  endfunction

  task automatic check(input string nm, input logic [3:0] epc, input logic [2:0] esp,
                       input logic eerr, input logic eep);
    logic [3:0] ebus;
    logic       efull, eempty;
    ebus   = eep ? epc : 4'd0;
    efull  = (esp == 3'd4);
    eempty = (esp == 3'd0);
    nvec++;
    if (pc !== epc || sp !== esp || stack_err !== eerr || bus_out !== ebus ||
        stack_full !== efull || stack_empty !== eempty) begin
      nbad++;
      $display("FAIL %s: got pc=%0d sp=%0d err=%b bus=%0d full=%b empty=%b, want pc=%0d sp=%0d err=%b bus=%0d full=%b empty=%b",
               nm, pc, sp, stack_err, bus_out, stack_full, stack_empty,
               epc, esp, eerr, ebus, efull, eempty);
    end
  endtask

  task automatic drive(input vec_t t);
    CLR = t.clr; Cp = t.cp; Ej = t.ej; Ecall = t.ecall; Eret = t.eret; Ep = t.ep;
    Addr = t.addr;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, want finish before 100000");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t idle;
    idle = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    //            clr cp ej ca rt ep addr pc sp err
    // Held CLR blocks Cp, then 17 increments with wrap
    tbl.push_back(v(1, 1, 0, 0, 0, 1, 0,  0, 0, 0));
    for (int i = 1; i <= 17; i++)
      tbl.push_back(v(0, 1, 0, 0, 0, 1, 0, i % 16, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0,  1, 0, 0));
    // Jump beats increment
    tbl.push_back(v(0, 0, 1, 0, 0, 1, 5,  5, 0, 0));
    tbl.push_back(v(0, 1, 1, 0, 0, 1, 9,  9, 0, 0));
    // Call / increment / return
    tbl.push_back(v(0, 0, 1, 0, 0, 0, 3,  3, 0, 0));
    tbl.push_back(v(0, 0, 0, 1, 0, 1, 12, 12, 1, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 0, 13, 1, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 0, 14, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 1, 0,  4, 0, 0));
    // Fill to overflow, then unwind
    tbl.push_back(v(0, 0, 1, 0, 0, 0, 0,  0, 0, 0));
    for (int i = 1; i <= 4; i++)
      tbl.push_back(v(0, 0, 0, 1, 0, 1, i, i, i, 0));
    tbl.push_back(v(0, 0, 0, 1, 0, 1, 5,  4, 4, 1));
    for (int i = 4; i >= 1; i--)
      tbl.push_back(v(0, 0, 0, 0, 1, 1, 0, i, i - 1, 1));
    // Underflow on empty stack
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0,  0, 0, 0));
    tbl.push_back(v(0, 0, 1, 0, 0, 0, 6,  6, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 1, 0,  6, 0, 1));
    // Call and return on the same edge: return wins
    tbl.push_back(v(1, 0, 0, 1, 0, 0, 3,  0, 0, 0));
    tbl.push_back(v(0, 0, 1, 0, 0, 0, 7,  7, 0, 0));
    tbl.push_back(v(0, 0, 0, 1, 0, 0, 10, 10, 1, 0));
    tbl.push_back(v(0, 0, 0, 1, 1, 1, 2,  8, 0, 0));
    // Return address wraps when calling from pc=15
    tbl.push_back(v(0, 0, 1, 0, 0, 0, 15, 15, 0, 0));
    tbl.push_back(v(0, 0, 0, 1, 0, 1, 3,  3, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 1, 0,  0, 0, 0));

    // Asynchronous reset before any clock edge
    CLR = 1'b1; Cp = 0; Ej = 0; Ecall = 0; Eret = 0; Ep = 1'b1; Addr = 4'd0;
    #1;
    check("reset_no_clock", 4'd0, 3'd0, 1'b0, 1'b1);

    foreach (tbl[i]) begin
      @(negedge CLK);
      drive(tbl[i]);
      @(posedge CLK);
      #1;
      check($sformatf("vec%0d", i), tbl[i].pc, tbl[i].sp, tbl[i].err, tbl[i].ep);
    end

    // Build up sp=1, err=1, then assert CLR between edges during a Cp run
    @(negedge CLK); drive(idle); Eret = 1'b1;
    @(negedge CLK); drive(idle); Ecall = 1'b1; Addr = 4'd2;
    @(negedge CLK); drive(idle); Cp = 1'b1;
    @(posedge CLK); #1;
    check("pre_clr_state", 4'd3, 3'd1, 1'b1, 1'b0);
    #2;
    CLR = 1'b1;
    #1;
    check("clr_mid_cycle", 4'd0, 3'd0, 1'b0, 1'b0);
    Ecall = 1'b1; Addr = 4'd9;
    repeat (2) @(posedge CLK);
    #1;
    check("clr_held_blocks", 4'd0, 3'd0, 1'b0, 1'b0);
    @(negedge CLK); drive(idle); Cp = 1'b1; Ep = 1'b1;
    @(posedge CLK); #1;
    check("after_clr_release", 4'd1, 3'd0, 1'b0, 1'b1);
    Ep = 1'b0;
    #1;
    check("ep_comb_off", 4'd1, 3'd0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
